// File: rtl/relu_wb_pkg.sv
// relu_wb_pkg: shared types and sizing for the ReLU write-back stage.
// Holds the write-back FSM state enum, default geometry, the row width and
// the FIFO pointer width (log2 depth + 1 wrap bit for full/empty detection).
package relu_wb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } wb_state_e;

  localparam int unsigned DATA_W_DEF     = 4;
  localparam int unsigned DIM_DEF        = 64;
  localparam int unsigned ADDR_W_DEF     = 8;
  localparam int unsigned FIFO_DEPTH_DEF = 4;

  localparam int unsigned ROW_W_DEF = DATA_W_DEF * DIM_DEF;

  // Pointer width for a FIFO of the given depth, including the wrap bit.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return 32'($clog2(depth)) + 32'd1;
  endfunction

  localparam int unsigned FIFO_PTR_W_DEF = ptr_width(FIFO_DEPTH_DEF);

endpackage

// File: rtl/wb_row_fifo.sv
// wb_row_fifo: synchronous row FIFO with a registered head.
// Ports:
//   clk, rst_n      clock, async active-low reset (flushes contents)
//   push, push_data write a row (caller guarantees !full || pop)
//   pop             drop the head row
//   head            registered head row
//   empty, full     registered status flags
//   empty_d_c       emptiness after this cycle's push/pop (combinational)
//   head_d_c        head row after this cycle's push/pop (combinational)
module wb_row_fifo
  import relu_wb_pkg::*;
#(
  parameter int unsigned WIDTH = ROW_W_DEF,
  parameter int unsigned DEPTH = FIFO_DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full,
  output logic             empty_d_c,
  output logic [WIDTH-1:0] head_d_c
);

  localparam int unsigned PTR_W = ptr_width(DEPTH);
  localparam int unsigned IDX_W = PTR_W - 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W-1:0] wr_ptr_d, rd_ptr_d;
  logic             full_d;

  // Next pointers, flags and head; a row pushed into the slot that becomes
  // the head this cycle is forwarded straight from push_data.
  always_comb begin
    wr_ptr_d  = wr_ptr + PTR_W'(push);
    rd_ptr_d  = rd_ptr + PTR_W'(pop);
    empty_d_c = (wr_ptr_d == rd_ptr_d);
    full_d    = ((wr_ptr_d - rd_ptr_d) == PTR_W'(DEPTH));
    head_d_c  = head;
    if (!empty_d_c) begin
      if (push && (rd_ptr_d == wr_ptr)) begin
        head_d_c = push_data;
      end else begin
        head_d_c = mem[rd_ptr_d[IDX_W-1:0]];
      end
    end
  end

  // Pointer, flag and head registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
      head   <= '0;
    end else begin
      wr_ptr <= wr_ptr_d;
      rd_ptr <= rd_ptr_d;
      empty  <= empty_d_c;
      full   <= full_d;
      head   <= head_d_c;
    end
  end

  // Row storage; contents are don't-care while the pointers say empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[IDX_W-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/relu_writeback.sv
// relu_writeback: buffers quantised ReLU rows and writes them to consecutive
// activation-memory addresses under a valid/ready handshake.
// Build option: RELU_WB_ZERO_SKIP_EN -- all-zero head rows are popped without
// a memory write (address and row count still advance).
// Ports:
//   clk, rst_n           clock, async active-low reset
//   start                latch base_addr/num_rows (honoured in IDLE only)
//   base_addr, num_rows  first address and row count of the job
//   relu_valid/relu_data incoming row, lane 0 in the LSBs
//   wb_en/wb_addr/wb_data/wb_ready  memory write handshake
//   busy                 high in RUN and DONE
//   done                 one-cycle completion pulse
//   overflow             sticky: a row was dropped on a full FIFO
module relu_writeback
  import relu_wb_pkg::*;
#(
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned DIM        = DIM_DEF,
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [ADDR_W-1:0]     num_rows,
  input  logic                  relu_valid,
  input  logic [DATA_W*DIM-1:0] relu_data,
  output logic                  wb_en,
  output logic [ADDR_W-1:0]     wb_addr,
  output logic [DATA_W*DIM-1:0] wb_data,
  input  logic                  wb_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow
);

  localparam int unsigned ROW_W = DATA_W * DIM;

`ifdef RELU_WB_ZERO_SKIP_EN
  localparam bit ZERO_SKIP = 1'b1;
`else
  localparam bit ZERO_SKIP = 1'b0;
`endif

  wb_state_e         state_q, state_d;
  logic [ADDR_W-1:0] num_rows_q;
  logic [ADDR_W-1:0] acc_cnt;
  logic [ADDR_W-1:0] wr_cnt;

  logic             fifo_push, fifo_pop;
  logic             fifo_empty, fifo_full, fifo_empty_d;
  logic [ROW_W-1:0] fifo_head_d;

  logic start_ok, push_req, drop, skip_pop, last_row, wb_en_d;

  wb_row_fifo #(
    .WIDTH (ROW_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (relu_data),
    .pop       (fifo_pop),
    .head      (wb_data),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .empty_d_c (fifo_empty_d),
    .head_d_c  (fifo_head_d)
  );

  // Next state, FIFO control and next write-enable.
  always_comb begin
    state_d   = state_q;
    start_ok  = (state_q == ST_IDLE) && start;
    skip_pop  = ZERO_SKIP && (state_q == ST_RUN) && !fifo_empty && (wb_data == '0);
    fifo_pop  = (wb_en && wb_ready) || skip_pop;
    last_row  = (wr_cnt == (num_rows_q - ADDR_W'(1)));
    push_req  = relu_valid && (state_q == ST_RUN) && (acc_cnt < num_rows_q);
    fifo_push = push_req && (!fifo_full || fifo_pop);
    drop      = push_req && fifo_full && !fifo_pop;

    unique case (state_q)
      ST_IDLE: if (start) state_d = (num_rows == '0) ? ST_DONE : ST_RUN;
      ST_RUN:  if (fifo_pop && last_row) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Registered wb_en tracks what the FIFO and FSM will look like next cycle.
    wb_en_d = (state_d == ST_RUN) && !fifo_empty_d &&
              (!ZERO_SKIP || (fifo_head_d != '0));
  end

  // State, counters, address and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      num_rows_q <= '0;
      acc_cnt    <= '0;
      wr_cnt     <= '0;
      wb_addr    <= '0;
      wb_en      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      state_q <= state_d;
      wb_en   <= wb_en_d;
      busy    <= (state_d != ST_IDLE);
      done    <= (state_d == ST_DONE);
      if (start_ok) begin
        num_rows_q <= num_rows;
        wb_addr    <= base_addr;
        acc_cnt    <= '0;
        wr_cnt     <= '0;
        overflow   <= 1'b0;
      end else begin
        if (fifo_push) acc_cnt <= acc_cnt + ADDR_W'(1);
        // wb_addr tracks base_addr + wr_cnt and wraps silently.
        if (fifo_pop) begin
          wr_cnt  <= wr_cnt + ADDR_W'(1);
          wb_addr <= wb_addr + ADDR_W'(1);
        end
        if (drop) overflow <= 1'b1;
      end
    end
  end

endmodule

// File: doc/relu_writeback.md
# relu_writeback

Write-back stage directly downstream of the near-memory aggregation/ReLU stage. Accepts one quantised activation row (DIM lanes × DATA_W bits) per valid cycle, buffers rows in a small FIFO, and writes them to consecutive activation-memory addresses under a valid/ready handshake. Rows are counted against a programmed row count, and completion is signalled with a one-cycle `done` pulse.

## Interface
- DATA_W, default 4: bits per activation lane; matches the ReLU output precision.
- DIM, default 64: lanes per row.
- ADDR_W, default 8: activation-memory address width.
- FIFO_DEPTH, default 4: row buffer depth; must be a power of two and at least 2.

- clk  in  1  single clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; latches `base_addr` and `num_rows`. Honoured only in IDLE.
- base_addr  in  ADDR_W  first write-back address.
- num_rows  in  ADDR_W  number of rows to write. A value of 0 completes immediately.
- relu_valid  in  1  `relu_data` is valid this cycle.
- relu_data  in  DATA_W*DIM  activation row; lane 0 occupies the LSBs.
- wb_en  out  1  write request to memory.
- wb_addr  out  ADDR_W  write address.
- wb_data  out  DATA_W*DIM  write data.
- wb_ready  in  1  memory accepts the write when `wb_en` && `wb_ready`.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle completion pulse.
- overflow  out  1  sticky flag: a row was dropped because the FIFO was full.

## Operation
- FSM has three states: IDLE, RUN and DONE.
  - IDLE → RUN on `start` when `num_rows` != 0.
  - IDLE → DONE on `start` when `num_rows` == 0.
  - RUN → DONE on the cycle the handshake for row `num_rows`-1 completes.
  - DONE → IDLE unconditionally. `done` is high only in DONE.
- `start` also clears `overflow`, the accepted-row count `acc_cnt` and the written-row count `wr_cnt`. `start` outside IDLE is ignored.
- Push rule: push when `relu_valid` && state==RUN && `acc_cnt` < `num_rows`. On each push, `acc_cnt` increments.
  - `relu_valid` in IDLE or DONE is ignored.
  - Rows arriving after `acc_cnt` reaches `num_rows` are ignored.
- FIFO full and no pop in the same cycle: the row is dropped, `overflow` sets, and `acc_cnt` does not increment.
- FIFO full with a pop in the same cycle: the push succeeds.
- `wb_en` = FIFO non-empty && state==RUN. `wb_data` = FIFO head.
- `wb_addr` = (`base_addr` + `wr_cnt`) mod 2^ADDR_W; the address wraps silently.
- A handshake pops the FIFO and increments `wr_cnt`.
- `wb_data` and `wb_addr` must hold stable while `wb_en` && !`wb_ready`.
- Reset mid-operation: return to IDLE, flush the FIFO, and drop all pending rows.

## Timing
- Reset values: `wb_en`=0, `wb_addr`=0, `wb_data`=0, `busy`=0, `done`=0, `overflow`=0. All counters are 0 and the FIFO is empty.
- Latency: a row pushed at edge N into an empty FIFO appears with `wb_en`=1 in the cycle after edge N (registered FIFO, no bypass).
- Throughput: one row per cycle with `wb_ready` tied high.
- `done` goes high the cycle after the final handshake. `busy` falls together with `done`.
- `start` with `num_rows`=0: `done` is high in the cycle after `start`.

## Configuration
- RELU_WB_ZERO_SKIP_EN
  - Defined: when a FIFO head row is all zero, it is popped without asserting `wb_en`, taking one cycle. `wr_cnt` and the address still advance, and that row counts toward completion.
  - Undefined: every row is written, including all-zero rows.

## Structure
- Package `relu_wb_pkg` holds:
  - the state enum (IDLE, RUN, DONE);
  - localparams for the row width (DATA_W*DIM) and the FIFO pointer width (log2 FIFO_DEPTH + 1, extra wrap bit for full/empty).
- Sub-module `wb_row_fifo`: synchronous FIFO with push/pop/full/empty, a registered head output, and a flush on reset.
- The top level holds the FSM, counters, address generation and the skip logic.

## Test plan
- Basic run: `start` with `base_addr`=0x10, `num_rows`=3, `wb_ready`=1, then 3 consecutive valid rows → writes to 0x10, 0x11, 0x12 in consecutive cycles; `done` follows the last write.
- Backpressure: `num_rows`=6, 6 back-to-back rows, `wb_ready` low for 8 cycles. With FIFO_DEPTH=4, rows 5 and 6 are dropped and `overflow`=1. Wait ≥3 cycles after the last row, then hold `relu_valid` low while raising `wb_ready` → rows 1–4 are written. Feed 2 more valid rows → total of 6 writes, then `done`.
- Wrap-around: `base_addr`=0xFE, `num_rows`=4 → addresses 0xFE, 0xFF, 0x00, 0x01.
- Boundaries: `num_rows`=0 → `done` the cycle after `start` and no writes. An extra 4th row with `num_rows`=3 → ignored. `start` while busy → ignored.
- Reset mid-run: assert `rst_n` low after 2 of 5 writes → all outputs return to 0 and the FIFO is empty. A new `start` restarts at `base_addr`.
- Zero skip (macro defined): rows A, 0, B at base 0x20 → writes only to 0x20 and 0x22; `done` after the write to 0x22.
